// File: rtl/buzz_tone_player_if.sv
// Note handshake between the melody sequencer (master) and the buzzer tone player (slave).
interface buzz_tone_player_if;
    logic        note_valid;
    logic        note_ready;
    logic [15:0] note_period;
    logic [15:0] note_dur;

    modport master (
        output note_valid,
        output note_period,
        output note_dur,
        input  note_ready
    );

    modport slave (
        input  note_valid,
        input  note_period,
        input  note_dur,
        output note_ready
    );
endinterface

// File: rtl/buzz_tone_player.sv
// Programmable piezo tone player: plays (half-period, duration) notes as a square wave,
// followed by a fixed silent gap, with a synchronous stop that aborts from any state.
module buzz_tone_player #(
    parameter int   TICK_DIV   = 50000,
    parameter int   GAP_TICKS  = 10,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    buzz_tone_player_if.slave note_if,
    input  logic              stop,
    output logic              busy,
    output logic              out
);

    localparam int              PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);
    localparam logic [15:0]      GAP_T   = 16'(GAP_TICKS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      period_q, period_d;
    logic [15:0]      dur_q, dur_d;
    logic [15:0]      half_q, half_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [15:0]      tick_q, tick_d;
    logic             out_q, out_d;

    logic             pre_wrap;
    logic [15:0]      tick_inc;

    assign pre_wrap = (pre_q == PRE_MAX);
    assign tick_inc = tick_q + 16'd1;

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        dur_d    = dur_q;
        half_d   = half_q;
        pre_d    = pre_q;
        tick_d   = tick_q;
        out_d    = out_q;

        // stop outranks every other event, including a handshake and end-of-note
        if (stop) begin
            state_d = IDLE;
            out_d   = IDLE_LEVEL;
            half_d  = 16'd0;
            pre_d   = '0;
            tick_d  = 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (note_if.note_valid) begin
                        period_d = note_if.note_period;
                        dur_d    = note_if.note_dur;
                        half_d   = 16'd0;
                        pre_d    = '0;
                        tick_d   = 16'd0;
                        if (note_if.note_dur != 16'd0) begin
                            state_d = TONE;
                        end
                    end
                end

                TONE: begin
                    if (period_q != 16'd0) begin
                        if (half_q == period_q - 16'd1) begin
                            half_d = 16'd0;
                            out_d  = ~out_q;
                        end else begin
                            half_d = half_q + 16'd1;
                        end
                    end else begin
                        out_d = IDLE_LEVEL;
                    end

                    // end-of-note is evaluated last so it overrides a coincident toggle
                    if (pre_wrap) begin
                        pre_d  = '0;
                        tick_d = tick_inc;
                        if (tick_inc == dur_q) begin
                            out_d   = IDLE_LEVEL;
                            half_d  = 16'd0;
                            tick_d  = 16'd0;
                            state_d = (GAP_T == 16'd0) ? IDLE : GAP;
                        end
                    end else begin
                        pre_d = pre_q + PRE_ONE;
                    end
                end

                GAP: begin
                    out_d = IDLE_LEVEL;
                    if (pre_wrap) begin
                        pre_d  = '0;
                        tick_d = tick_inc;
                        if (tick_inc == GAP_T) begin
                            tick_d  = 16'd0;
                            state_d = IDLE;
                        end
                    end else begin
                        pre_d = pre_q + PRE_ONE;
                    end
                end

                default: begin
                    state_d = IDLE;
                    out_d   = IDLE_LEVEL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            period_q <= 16'd0;
            dur_q    <= 16'd0;
            half_q   <= 16'd0;
            pre_q    <= '0;
            tick_q   <= 16'd0;
            out_q    <= IDLE_LEVEL;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            dur_q    <= dur_d;
            half_q   <= half_d;
            pre_q    <= pre_d;
            tick_q   <= tick_d;
            out_q    <= out_d;
        end
    end

    assign note_if.note_ready = (state_q == IDLE) && !stop;
    assign busy               = (state_q != IDLE);
    assign out                = out_q;

endmodule
